// File: rtl/game_pkg.sv
// Shared types for the throw/turn game controller.
// Provides the controller state encoding, the player identifier and the
// width of the throw power value.
package game_pkg;

  localparam int unsigned POWER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_PRESS = 3'd1,
    ST_CHARGE     = 3'd2,
    ST_WAIT_ANIM  = 3'd3,
    ST_FLIGHT     = 3'd4,
    ST_SWITCH     = 3'd5
  } ctrl_state_t;

  typedef enum logic {
    CAT = 1'b0,
    DOG = 1'b1
  } player_t;

  // States in which the active player's turn_active is asserted.
  function automatic logic is_turn_state(input ctrl_state_t s);
    return (s == ST_WAIT_PRESS) || (s == ST_CHARGE) ||
           (s == ST_WAIT_ANIM)  || (s == ST_FLIGHT);
  endfunction

endpackage

// File: rtl/power_charger.sv
// Throw power accumulator: a clock divider plus a saturating power counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : restart charging, power <= POWER_MIN
//   enable    : charging phase active
//   hold      : freeze divider and power while enabled
//   power     : registered power value
module power_charger
  import game_pkg::*;
#(
  parameter int unsigned        CHARGE_DIV = 650000,
  parameter logic [POWER_W-1:0] POWER_MIN  = 8'd1,
  parameter logic [POWER_W-1:0] POWER_MAX  = 8'd100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               enable,
  input  logic               hold,
  output logic [POWER_W-1:0] power
);

  localparam int unsigned DIV_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  // The load cycle already counts as the first charging cycle.
  localparam logic [DIV_W-1:0] DIV_START = (CHARGE_DIV > 1) ? DIV_W'(1) : '0;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CHARGE_DIV - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [POWER_W-1:0] power_q, power_d;

  // Next divider/power value.
  always_comb begin
    div_d   = div_q;
    power_d = power_q;
    if (load) begin
      div_d   = DIV_START;
      power_d = POWER_MIN;
    end else if (enable && !hold) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (power_q < POWER_MAX) begin
          power_d = power_q + POWER_W'(1);
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      power_q <= '0;
    end else begin
      div_q   <= div_d;
      power_q <= power_d;
    end
  end

  assign power = power_q;

endmodule

// File: rtl/throw_turn_ctrl.sv
// Turn/throw handshake controller for the cat and dog players.
// Measures throw power from button hold time, commands the active sprite to
// throw, launches the projectile after the throw animation, waits for it to
// land and hands the turn over.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : one-cycle game start pulse (honoured in IDLE only)
//   game_over            : level, forces IDLE with priority over all events
//   btn                  : synchronised throw button
//   throw_complete_cat/dog : sprite throw-finished pulses
//   projectile_done      : projectile finished pulse
//   turn_cat/dog         : turn_active to each sprite drawer
//   throw_command_cat/dog: throw_command to each sprite drawer
//   power                : charged throw power
//   launch               : one-cycle projectile start pulse
//   thrower              : active player (0 cat, 1 dog)
// Build option: define TURN_TIMEOUT_EN to pass the turn after TIMEOUT_CYCLES
// idle cycles in WAIT_PRESS.
module throw_turn_ctrl
  import game_pkg::*;
#(
  parameter int unsigned        CHARGE_DIV     = 650000,
  parameter logic [POWER_W-1:0] POWER_MIN      = 8'd1,
  parameter logic [POWER_W-1:0] POWER_MAX      = 8'd100,
  parameter logic               FIRST_DOG      = 1'b0,
  parameter logic [31:0]        TIMEOUT_CYCLES = 32'd650000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               game_over,
  input  logic               btn,
  input  logic               throw_complete_cat,
  input  logic               throw_complete_dog,
  input  logic               projectile_done,
  output logic               turn_cat,
  output logic               turn_dog,
  output logic               throw_command_cat,
  output logic               throw_command_dog,
  output logic [POWER_W-1:0] power,
  output logic               launch,
  output logic               thrower
);

  ctrl_state_t state_q, state_d;
  player_t     thrower_q, thrower_d;
  logic        btn_prev_q;
  logic        launch_q, launch_d;
  logic        turn_cat_q, turn_cat_d;
  logic        turn_dog_q, turn_dog_d;
  logic        cmd_cat_q, cmd_cat_d;
  logic        cmd_dog_q, cmd_dog_d;
  logic        press_c;
  logic        tc_active_c;
  logic        chg_load_c;
  logic        chg_enable_c;

`ifdef TURN_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
`else
  logic        timeout_unused;
  assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

  assign press_c     = btn && !btn_prev_q;
  assign tc_active_c = (thrower_q == DOG) ? throw_complete_dog : throw_complete_cat;

  // Next state, handshake outputs and charger control.
  always_comb begin
    state_d    = state_q;
    thrower_d  = thrower_q;
    launch_d   = 1'b0;
    chg_load_c = 1'b0;
`ifdef TURN_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif

    if (game_over) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            thrower_d = player_t'(FIRST_DOG);
            state_d   = ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (press_c) begin
            chg_load_c = 1'b1;
            state_d    = ST_CHARGE;
          end
`ifdef TURN_TIMEOUT_EN
          else if (idle_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            state_d = ST_SWITCH;
          end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
          end
`endif
        end
        ST_CHARGE: begin
          if (!btn) begin
            state_d = ST_WAIT_ANIM;
          end
        end
        ST_WAIT_ANIM: begin
          if (tc_active_c) begin
            launch_d = 1'b1;
            state_d  = ST_FLIGHT;
          end
        end
        ST_FLIGHT: begin
          if (projectile_done) begin
            state_d = ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          thrower_d = (thrower_q == CAT) ? DOG : CAT;
          state_d   = ST_WAIT_PRESS;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

`ifdef TURN_TIMEOUT_EN
    if ((state_d == ST_WAIT_PRESS) && (state_q != ST_WAIT_PRESS)) begin
      idle_cnt_d = '0;
    end
`endif

    // Outputs follow the next state so they line up with it on the same edge.
    turn_cat_d = is_turn_state(state_d) && (thrower_d == CAT);
    turn_dog_d = is_turn_state(state_d) && (thrower_d == DOG);
    cmd_cat_d  = (state_d == ST_CHARGE) && (thrower_d == CAT);
    cmd_dog_d  = (state_d == ST_CHARGE) && (thrower_d == DOG);
  end

  assign chg_enable_c = (state_q == ST_CHARGE) && !game_over;

  power_charger #(
    .CHARGE_DIV (CHARGE_DIV),
    .POWER_MIN  (POWER_MIN),
    .POWER_MAX  (POWER_MAX)
  ) u_power_charger (
    .clk    (clk),
    .rst    (rst),
    .load   (chg_load_c),
    .enable (chg_enable_c),
    .hold   (!btn),
    .power  (power)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      thrower_q  <= player_t'(FIRST_DOG);
      btn_prev_q <= 1'b0;
      launch_q   <= 1'b0;
      turn_cat_q <= 1'b0;
      turn_dog_q <= 1'b0;
      cmd_cat_q  <= 1'b0;
      cmd_dog_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      thrower_q  <= thrower_d;
      btn_prev_q <= btn;
      launch_q   <= launch_d;
      turn_cat_q <= turn_cat_d;
      turn_dog_q <= turn_dog_d;
      cmd_cat_q  <= cmd_cat_d;
      cmd_dog_q  <= cmd_dog_d;
    end
  end

`ifdef TURN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  assign turn_cat          = turn_cat_q;
  assign turn_dog          = turn_dog_q;
  assign throw_command_cat = cmd_cat_q;
  assign throw_command_dog = cmd_dog_q;
  assign launch            = launch_q;
  assign thrower           = logic'(thrower_q);

endmodule
